// File: rtl/mem_pkg.sv
// Shared definitions for the DDR burst engines (read today, write later).
// Holds the engine state encoding, the controller read opcode and the
// default per-beat address increment.
package mem_pkg;

  localparam int unsigned BURST_LEN_W       = 8;
  localparam int unsigned DEFAULT_ADDR_STEP = 8;
  localparam logic [2:0]  APP_CMD_READ      = 3'b001;

  typedef logic [BURST_LEN_W-1:0] burst_len_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

endpackage

// File: rtl/mem_burst_read_if.sv
// Bus bundle between a user read port, the burst read engine and the
// memory controller app interface.
//   user side : rd_ddr_req/len/addr in, rd_ddr_data_valid/data/finish, rd_timeout out
//   app side  : app_en/cmd/addr out, app_rdy, app_rd_data_valid/data in
// slave  = the burst read engine
// master = the environment (user logic plus memory controller)
interface mem_burst_read_if #(
  parameter int unsigned ADDR_WIDTH    = 30,
  parameter int unsigned MEM_DATA_BITS = 256
);

  logic                     rd_ddr_req;
  mem_pkg::burst_len_t      rd_ddr_len;
  logic [ADDR_WIDTH-1:0]    rd_ddr_addr;
  logic                     rd_ddr_data_valid;
  logic [MEM_DATA_BITS-1:0] rd_ddr_data;
  logic                     rd_ddr_finish;
  logic                     rd_timeout;

  logic                     app_en;
  logic [2:0]               app_cmd;
  logic [ADDR_WIDTH-1:0]    app_addr;
  logic                     app_rdy;
  logic                     app_rd_data_valid;
  logic [MEM_DATA_BITS-1:0] app_rd_data;

  modport slave (
    input  rd_ddr_req, rd_ddr_len, rd_ddr_addr,
    output rd_ddr_data_valid, rd_ddr_data, rd_ddr_finish, rd_timeout,
    output app_en, app_cmd, app_addr,
    input  app_rdy, app_rd_data_valid, app_rd_data
  );

  modport master (
    output rd_ddr_req, rd_ddr_len, rd_ddr_addr,
    input  rd_ddr_data_valid, rd_ddr_data, rd_ddr_finish, rd_timeout,
    input  app_en, app_cmd, app_addr,
    output app_rdy, app_rd_data_valid, app_rd_data
  );

endinterface

// File: rtl/mem_burst_read.sv
// Burst read engine: on a rising edge of rd_ddr_req it issues rd_ddr_len
// read commands to the memory controller at consecutive ADDR_STEP-spaced
// addresses, forwards the returned beats one cycle later and pulses
// rd_ddr_finish once all beats are back. A busy watchdog aborts a stuck
// transaction with a rd_timeout pulse.
// Ports:
//   ddr_clk_i  clock, rising edge
//   ddr_rst_i  asynchronous active-high reset
//   bus        mem_burst_read_if slave modport (user request/response and
//              memory controller command/read-data signals)
module mem_burst_read
  import mem_pkg::*;
#(
  parameter real         TCQ           = 0.1,
  parameter int unsigned MEM_DATA_BITS = 256,
  parameter int unsigned ADDR_WIDTH    = 30,
  parameter int unsigned ADDR_STEP     = DEFAULT_ADDR_STEP,
  parameter int unsigned TIMEOUT       = 8000
) (
  input  logic            ddr_clk_i,
  input  logic            ddr_rst_i,
  mem_burst_read_if.slave bus
);

  localparam int unsigned LEN_W  = BURST_LEN_W;
  localparam int unsigned BUSY_W = $clog2(TIMEOUT + 1);

  // TCQ only matters to delay-annotated models; this RTL is delay free.
  if (TCQ < 0.0) begin : g_tcq_negative
  end

  mem_state_e               state;
  mem_state_e               next_state;

  logic                     req_d0;
  burst_len_t               len_q;
  burst_len_t               cmd_cnt;
  burst_len_t               data_cnt;
  logic [BUSY_W-1:0]        busy_cnt;

  logic [ADDR_WIDTH-1:0]    app_addr_q;
  logic                     app_en_q;
  logic                     rd_valid_q;
  logic [MEM_DATA_BITS-1:0] rd_data_q;
  logic                     finish_q;
  logic                     timeout_q;

  logic                     busy;
  logic                     req_edge;
  logic                     cmd_fire;
  logic                     last_cmd;
  logic                     beat;
  logic                     data_done;
  logic                     timeout_hit;
  logic                     start;
  logic                     abort;

  // Transaction event decode
  assign busy        = (state == ST_CMD) || (state == ST_WAIT);
  assign req_edge    = bus.rd_ddr_req && !req_d0;
  assign cmd_fire    = (state == ST_CMD) && app_en_q && bus.app_rdy;
  assign last_cmd    = cmd_fire && (cmd_cnt == (len_q - LEN_W'(1)));
  assign beat        = busy && bus.app_rd_data_valid;
  assign data_done   = beat && ((data_cnt + LEN_W'(1)) == len_q);
  // Fires on the last of TIMEOUT busy cycles so a transaction never exceeds it.
  assign timeout_hit = busy && (busy_cnt == BUSY_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge ddr_clk_i or posedge ddr_rst_i) begin
    if (ddr_rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state; completion wins over the watchdog when both land together
  always_comb begin
    next_state = state;
    start      = 1'b0;
    abort      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_edge) begin
          start      = 1'b1;
          next_state = (bus.rd_ddr_len == '0) ? ST_DONE : ST_CMD;
        end
      end
      ST_CMD: begin
        if (data_done) begin
          next_state = ST_DONE;
        end else if (timeout_hit) begin
          abort      = 1'b1;
          next_state = ST_IDLE;
        end else if (last_cmd) begin
          next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (data_done) begin
          next_state = ST_DONE;
        end else if (timeout_hit) begin
          abort      = 1'b1;
          next_state = ST_IDLE;
        end
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Request edge detector
  always_ff @(posedge ddr_clk_i or posedge ddr_rst_i) begin
    if (ddr_rst_i) begin
      req_d0 <= 1'b0;
    end else begin
      req_d0 <= bus.rd_ddr_req;
    end
  end

  // Latched burst length and command/data/busy counters
  always_ff @(posedge ddr_clk_i or posedge ddr_rst_i) begin
    if (ddr_rst_i) begin
      len_q    <= '0;
      cmd_cnt  <= '0;
      data_cnt <= '0;
      busy_cnt <= '0;
    end else begin
      if (start) begin
        len_q <= bus.rd_ddr_len;
      end
      if (state == ST_IDLE) begin
        cmd_cnt  <= '0;
        data_cnt <= '0;
      end else begin
        if (cmd_fire) begin
          cmd_cnt <= cmd_cnt + LEN_W'(1);
        end
        if (beat) begin
          data_cnt <= data_cnt + LEN_W'(1);
        end
      end
      busy_cnt <= busy ? (busy_cnt + BUSY_W'(1)) : '0;
    end
  end

  // Command address: loaded at start, advanced per accepted command
  always_ff @(posedge ddr_clk_i or posedge ddr_rst_i) begin
    if (ddr_rst_i) begin
      app_addr_q <= '0;
    end else if (start) begin
      app_addr_q <= bus.rd_ddr_addr;
    end else if (cmd_fire) begin
      app_addr_q <= app_addr_q + ADDR_WIDTH'(ADDR_STEP);
    end
  end

  // Output register stage
  always_ff @(posedge ddr_clk_i or posedge ddr_rst_i) begin
    if (ddr_rst_i) begin
      app_en_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      finish_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      app_en_q   <= (next_state == ST_CMD);
      rd_valid_q <= beat;
      if (beat) begin
        rd_data_q <= bus.app_rd_data;
      end
      finish_q   <= (next_state == ST_DONE);
      timeout_q  <= abort;
    end
  end

  assign bus.app_en            = app_en_q;
  assign bus.app_cmd           = APP_CMD_READ;
  assign bus.app_addr          = app_addr_q;
  assign bus.rd_ddr_data_valid = rd_valid_q;
  assign bus.rd_ddr_data       = rd_data_q;
  assign bus.rd_ddr_finish     = finish_q;
  assign bus.rd_timeout        = timeout_q;

endmodule

// File: tb/tb_mem_burst_read.sv
// Bench for mem_burst_read: directed scenarios plus randomized bursts,
// a behavioural memory controller, and an event scoreboard checked per
// transaction against address arithmetic and beat windows.
module tb_mem_burst_read;
  import mem_pkg::*;

  localparam int unsigned AW   = 30;
  localparam int unsigned DW   = 256;
  localparam int unsigned STEP = 8;
  localparam int unsigned TMO  = 8000;

  typedef struct {
    logic [DW-1:0] d;
    int            c;
  } ev_t;

  logic ddr_clk_i = 1'b0;
  logic ddr_rst_i = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  ev_t  cmd_q[$];
  ev_t  abeat_q[$];
  ev_t  obeat_q[$];
  int   fin_q[$];
  int   to_q[$];

  // controller model configuration
  int   lat = 3;
  int   beat_limit = 1000;
  int   returned = 0;
  int   rdy_mode = 0;
  bit   pat_q[$];
  bit   rdy_q[$];
  int   ret_q[$];
  int   k_r = 0;

  logic             prev_stall = 1'b0;
  logic [AW-1:0]    prev_addr = '0;

  mem_burst_read_if #(.ADDR_WIDTH(AW), .MEM_DATA_BITS(DW)) bus ();

  mem_burst_read #(
    .TCQ(0.1), .MEM_DATA_BITS(DW), .ADDR_WIDTH(AW), .ADDR_STEP(STEP), .TIMEOUT(TMO)
  ) dut (
    .ddr_clk_i(ddr_clk_i),
    .ddr_rst_i(ddr_rst_i),
    .bus(bus)
  );

  initial forever #5 ddr_clk_i = ~ddr_clk_i;

  always @(posedge ddr_clk_i) cyc <= cyc + 1;

  task automatic chk_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Event recorder and inline protocol checks, sampled mid-cycle
  always @(negedge ddr_clk_i) begin
    if (ddr_rst_i) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.app_en) chk_int("app_cmd", int'(bus.app_cmd), int'(APP_CMD_READ));
      if (prev_stall && bus.app_en) chk_vec("addr_hold", DW'(bus.app_addr), DW'(prev_addr));
      prev_stall = bus.app_en && !bus.app_rdy;
      prev_addr  = bus.app_addr;
      if (bus.app_en && bus.app_rdy) cmd_q.push_back('{d: DW'(bus.app_addr), c: cyc});
      if (bus.app_rd_data_valid) abeat_q.push_back('{d: bus.app_rd_data, c: cyc});
      if (bus.rd_ddr_data_valid) obeat_q.push_back('{d: bus.rd_ddr_data, c: cyc});
      if (bus.rd_ddr_finish) fin_q.push_back(cyc);
      if (bus.rd_timeout) to_q.push_back(cyc);
    end
  end

  // One clock of the controller model; returns just after the rising edge
  task automatic step();
    @(negedge ddr_clk_i);
    if (bus.app_en && bus.app_rdy && !ddr_rst_i) ret_q.push_back(cyc + lat);
    @(posedge ddr_clk_i);
    #1;
    bus.app_rd_data_valid = 1'b0;
    while (ret_q.size() > 0 && ret_q[0] < cyc) void'(ret_q.pop_front());
    if (ret_q.size() > 0 && ret_q[0] == cyc) begin
      void'(ret_q.pop_front());
      if (returned < beat_limit) begin
        bus.app_rd_data_valid = 1'b1;
        bus.app_rd_data       = rand_word();
        returned++;
      end
    end
    case (rdy_mode)
      0:       bus.app_rdy = 1'b1;
      1:       bus.app_rdy = (rdy_q.size() != 0) ? rdy_q.pop_front() : 1'b1;
      default: bus.app_rdy = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic clear_events();
    cmd_q.delete(); abeat_q.delete(); obeat_q.delete(); fin_q.delete(); to_q.delete();
  endtask

  task automatic start_txn(input int len, input logic [AW-1:0] addr);
    clear_events();
    ret_q.delete();
    returned = 0;
    rdy_q = pat_q;
    bus.rd_ddr_req  = 1'b1;
    bus.rd_ddr_len  = 8'(len);
    bus.rd_ddr_addr = addr;
    k_r = cyc;
  endtask

  // Scoreboard: commands, forwarded beats and the closing pulse
  task automatic check_txn(input int len, input logic [AW-1:0] addr, input bit exp_to);
    int            k_end;
    int            seen;
    logic [AW-1:0] ea;
    ev_t           exp_q[$];
    chk_int("cmd_count", cmd_q.size(), len);
    foreach (cmd_q[i]) begin
      ea = addr + AW'(i) * AW'(STEP);
      chk_vec("cmd_addr", cmd_q[i].d, DW'(ea));
    end
    k_end = k_r;
    seen  = 0;
    if (exp_to) begin
      k_end = k_r + int'(TMO);
    end else begin
      foreach (abeat_q[i]) begin
        if (abeat_q[i].c > k_r && seen < len) begin
          seen++;
          if (seen == len) k_end = abeat_q[i].c;
        end
      end
    end
    foreach (abeat_q[i]) begin
      if (abeat_q[i].c > k_r && abeat_q[i].c <= k_end)
        exp_q.push_back('{d: abeat_q[i].d, c: abeat_q[i].c + 1});
    end
    chk_int("obeat_count", obeat_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < obeat_q.size()) begin
        chk_vec("obeat_data", obeat_q[i].d, exp_q[i].d);
        chk_int("obeat_cycle", obeat_q[i].c, exp_q[i].c);
      end
    end
    if (exp_to) begin
      chk_int("finish_count", fin_q.size(), 0);
      chk_int("timeout_count", to_q.size(), 1);
      if (to_q.size() > 0) chk_int("timeout_cycle", to_q[0], k_end + 1);
    end else begin
      chk_int("finish_count", fin_q.size(), 1);
      if (fin_q.size() > 0) chk_int("finish_cycle", fin_q[0], k_end + 1);
      chk_int("timeout_count", to_q.size(), 0);
    end
  endtask

  task automatic run_txn(input int len, input logic [AW-1:0] addr, input bit exp_to, input bit keep_req);
    bit ended;
    step();
    start_txn(len, addr);
    ended = 1'b0;
    for (int i = 0; i < int'(TMO) + 700 && !ended; i++) begin
      step();
      if (!keep_req && (obeat_q.size() != 0 || fin_q.size() != 0 || to_q.size() != 0))
        bus.rd_ddr_req = 1'b0;
      if (fin_q.size() != 0 || to_q.size() != 0) ended = 1'b1;
    end
    chk_int("txn_end_bound", int'(ended), 1);
    repeat (4) step();
    if (!keep_req) bus.rd_ddr_req = 1'b0;
    check_txn(len, addr, exp_to);
    pat_q.delete();
  endtask

  initial begin
    bus.rd_ddr_req        = 1'b0;
    bus.rd_ddr_len        = '0;
    bus.rd_ddr_addr       = '0;
    bus.app_rdy           = 1'b0;
    bus.app_rd_data_valid = 1'b0;
    bus.app_rd_data       = '0;
    ddr_rst_i             = 1'b1;

    // reset values
    repeat (3) @(posedge ddr_clk_i);
    #1;
    chk_int("rst_app_en", int'(bus.app_en), 0);
    chk_int("rst_rd_valid", int'(bus.rd_ddr_data_valid), 0);
    chk_int("rst_finish", int'(bus.rd_ddr_finish), 0);
    chk_int("rst_timeout", int'(bus.rd_timeout), 0);
    chk_vec("rst_rd_data", bus.rd_ddr_data, '0);
    chk_vec("rst_app_addr", DW'(bus.app_addr), '0);
    ddr_rst_i = 1'b0;

    // basic burst: 4 beats from 0x100, data 3 cycles after each command
    rdy_mode = 0; lat = 3;
    run_txn(4, 30'h100, 1'b0, 1'b0);

    // back-pressure pattern on app_rdy
    rdy_mode = 1; lat = 2;
    pat_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    run_txn(3, 30'h2000, 1'b0, 1'b0);

    // zero length, then a held level must not retrigger
    rdy_mode = 0;
    run_txn(0, 30'h440, 1'b0, 1'b1);
    clear_events();
    repeat (10) step();
    chk_int("level_no_cmd", cmd_q.size(), 0);
    chk_int("level_no_finish", fin_q.size(), 0);
    bus.rd_ddr_req = 1'b0;

    // watchdog: only one of two beats comes back
    beat_limit = 1;
    run_txn(2, 30'h800, 1'b1, 1'b0);
    beat_limit = 1000;

    // address wrap
    run_txn(2, 30'h3FFF_FFF8, 1'b0, 1'b0);

    // longest burst
    lat = 2;
    run_txn(255, AW'($urandom), 1'b0, 1'b0);

    // randomized bursts
    rdy_mode = 2;
    for (int n = 0; n < 8; n++) begin
      lat = $urandom_range(1, 6);
      run_txn($urandom_range(1, 40), AW'($urandom), 1'b0, 1'b0);
    end

    // reset in the middle of the command phase
    rdy_mode = 0; lat = 6;
    step();
    start_txn(8, 30'h1230);
    repeat (3) step();
    #2 ddr_rst_i = 1'b1;
    #1;
    chk_int("mid_rst_app_en", int'(bus.app_en), 0);
    chk_int("mid_rst_rd_valid", int'(bus.rd_ddr_data_valid), 0);
    chk_int("mid_rst_finish", int'(bus.rd_ddr_finish), 0);
    chk_vec("mid_rst_app_addr", DW'(bus.app_addr), '0);
    repeat (2) step();
    bus.rd_ddr_req = 1'b0;
    ddr_rst_i = 1'b0;
    clear_events();
    repeat (10) step();
    chk_int("stray_dropped", obeat_q.size(), 0);
    chk_int("stray_no_finish", fin_q.size(), 0);
    chk_int("stray_no_cmd", cmd_q.size(), 0);

    // recovery after reset
    lat = 3;
    run_txn(5, AW'($urandom), 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
